// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: clocked I2C target serving a DEPTH-byte register bank through an
// auto-incrementing pointer. SCL_I/SDA_I are oversampled in the clk domain.
// Optional clock stretching after every ACK/NACK slot: define I2C_REG_SLAVE_STRETCH_EN.
module i2c_reg_slave #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h50,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned PTR_W          = 4,
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCL_I,
  input  logic             SDA_I,
  output logic             SCL_O,
  output logic             SDA_O,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  if (DEPTH != (32'd1 << PTR_W) || STRETCH_CYCLES == 0) begin : g_param_check
    $error("i2c_reg_slave: DEPTH must equal 2**PTR_W and STRETCH_CYCLES must be nonzero");
  end

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t           state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             rw_q, rw_d;
  logic             ack_q, ack_d;
  logic             sda_o_q, sda_o_d;
  logic             busy_q, busy_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             reg_we;
  logic             byte_full;
  logic [7:0]       rd_cur, rd_nxt;
  logic [7:0]       regs_q [DEPTH];

  // Two-stage synchronizer plus one history stage per bus line; idle bus is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= '1;
      {sda_s1_q, sda_s2_q, sda_h_q} <= '1;
    end else begin
      scl_s1_q <= SCL_I;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= SDA_I;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;

  assign byte_full = (bitcnt_q == 4'd8);
  assign ptr_inc   = ptr_q + 1'b1;
  assign rd_cur    = regs_q[ptr_q];
  assign rd_nxt    = regs_q[ptr_inc];

  // Protocol FSM: bits are shifted on SCL rise; SDA_O only moves after an SCL fall.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_o_d    = sda_o_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_o_d  = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_o_d  = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: begin
          if (scl_rise && !byte_full) begin
            shift_d  = {shift_q[6:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && byte_full) begin
            bitcnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_o_d = 1'b0;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
              state_d = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end
        PTR: begin
          if (scl_rise && !byte_full) begin
            shift_d  = {shift_q[6:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && byte_full) begin
            bitcnt_d = '0;
            ptr_d    = shift_q[PTR_W-1:0];
            sda_o_d  = 1'b0;
            state_d  = PTR_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise && !byte_full) begin
            shift_d  = {shift_q[6:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && byte_full) begin
            bitcnt_d   = '0;
            reg_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            sda_o_d    = 1'b0;
            state_d    = WR_ACK;
          end
        end
        // ACK states are entered on an SCL fall, so the next fall closes the slot.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              shift_d = rd_cur;
              sda_o_d = rd_cur[7];
              state_d = RD_DATA;
            end else begin
              sda_o_d = 1'b1;
              state_d = PTR;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            state_d = WR_DATA;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            ptr_d   = ptr_inc;
            state_d = WR_DATA;
          end
        end
        // Bit 7 is already on SDA_O at entry; each fall presents the next bit.
        RD_DATA: begin
          if (scl_rise && !byte_full) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_full) begin
              bitcnt_d = '0;
              sda_o_d  = 1'b1;
              state_d  = RD_ACK;
            end else begin
              sda_o_d = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s2_q;
          end else if (scl_fall) begin
            ptr_d = ptr_inc;
            if (!ack_q) begin
              shift_d = rd_nxt;
              sda_o_d = rd_nxt[7];
              state_d = RD_DATA;
            end else begin
              sda_o_d = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      sda_o_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_o_q    <= sda_o_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register bank: cleared by reset, written at the end of each received data byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  assign host_rdata = regs_q[host_addr];
  assign SDA_O      = sda_o_q;
  assign busy       = busy_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

`ifdef I2C_REG_SLAVE_STRETCH_EN
  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] stretch_q;
  logic          slot_end;

  assign slot_end = scl_fall & ~start_det & ~stop_det &
                    (state_q inside {ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK});

  // Hold SCL low for STRETCH_CYCLES after each ACK/NACK slot; bus conditions cancel it.
  always_ff @(posedge clk) begin
    if (!rst || start_det || stop_det) stretch_q <= '0;
    else if (slot_end)                 stretch_q <= SW'(STRETCH_CYCLES);
    else if (stretch_q != '0)          stretch_q <= stretch_q - 1'b1;
  end

  assign SCL_O = (stretch_q == '0) | start_det | stop_det;
`else
  assign SCL_O = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bus-level master driving wired-AND SCL/SDA lines against a
// byte-level model of the register bank and pointer.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

  localparam int         Q       = 5;
  localparam int         DEPTH   = 16;
  localparam logic [6:0] ADDR    = 7'h50;
  localparam int         STRETCH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_line, sda_line;
  logic       SCL_O, SDA_O;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  always #5 clk = ~clk;

  assign scl_line = m_scl & SCL_O;
  assign sda_line = m_sda & SDA_O;

  i2c_reg_slave #(
    .SLAVE_ADDR(ADDR), .DEPTH(DEPTH), .PTR_W(4), .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk(clk), .rst(rst), .SCL_I(scl_line), .SDA_I(sda_line),
    .SCL_O(SCL_O), .SDA_O(SDA_O), .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [DEPTH];
  int          mptr;
  logic [11:0] exp_q [$];
  logic [7:0]  wdata_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_up();
    int n;
    n = 0;
    m_scl = 1'b1;
    while (scl_line !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (scl_line !== 1'b1) check("scl_release_timeout", scl_line, 1);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; tick(Q);
    scl_up();  tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    scl_up(); tick(Q / 2);
    b = sda_line; tick(Q - Q / 2);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    scl_up();     tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    scl_up();     tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = 4'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), host_rdata, mem[i]);
    end
  endtask

  // Addressed write: pointer byte then every byte queued in wdata_q.
  task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input bit do_stop);
    logic       ack;
    bit         hit;
    logic [7:0] d;
    hit = (a == ADDR);
    bus_start();
    send_byte({a, 1'b0}, ack);
    check("w_addr_ack", ack, !hit);
    if (hit) mptr = p % DEPTH;
    send_byte(p, ack);
    check("w_ptr_ack", ack, !hit);
    while (wdata_q.size() > 0) begin
      d = wdata_q.pop_front();
      if (hit) begin
        mem[mptr] = d;
        exp_q.push_back({4'(mptr), d});
        mptr = (mptr + 1) % DEPTH;
      end
      send_byte(d, ack);
      check("w_data_ack", ack, !hit);
    end
    check("w_busy", busy, hit);
    if (do_stop) begin
      bus_stop();
      check("w_busy_end", busy, 0);
      check("w_sda_rel", SDA_O, 1);
    end
  endtask

  // Read n bytes from the current pointer; master ACKs all but the last.
  task automatic xfer_read(input logic [6:0] a, input int n);
    logic       ack;
    bit         hit;
    logic [7:0] d;
    hit = (a == ADDR);
    bus_start();
    send_byte({a, 1'b1}, ack);
    check("r_addr_ack", ack, !hit);
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(d, i == n - 1);
        check("r_data", d, mem[mptr]);
        mptr = (mptr + 1) % DEPTH;
      end
      check("r_busy_wait", busy, 1);
      check("r_sda_rel", SDA_O, 1);
    end
    bus_stop();
    check("r_busy_end", busy, 0);
  endtask

  // Every wr_valid pulse must match the oldest expected register write.
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst === 1'b1 && wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", wr_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[11:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
  end

`ifdef I2C_REG_SLAVE_STRETCH_EN
  int low_run = 0;
  always @(negedge clk) begin
    if (SCL_O === 1'b0) begin
      low_run++;
    end else if (low_run != 0) begin
      check("stretch_len", low_run, STRETCH);
      low_run = 0;
    end
  end
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    int         kind;
    int         n;
    logic [6:0] a;

    rst = 1'b0;
    host_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mptr = 0;
    tick(4);
    check("rst_sda", SDA_O, 1);
    check("rst_scl", SCL_O, 1);
    check("rst_busy", busy, 0);
    check("rst_wrv", wr_valid, 0);
    check_regs("rst_reg");
    rst = 1'b1;
    tick(4);

    // Directed write: ptr 3, data A5 5A.
    wdata_q = '{8'hA5, 8'h5A};
    xfer_write(ADDR, 8'h03, 1'b1);
    check_regs("write_reg");

    // Pointer write then repeated START read of two bytes.
    xfer_write(ADDR, 8'h03, 1'b0);
    xfer_read(ADDR, 2);

    // Address mismatch: 0x51 followed by one byte.
    xfer_write(7'h51, 8'hFF, 1'b1);

    // Pointer wrap from 15 to 0.
    wdata_q = '{8'h11, 8'h22};
    xfer_write(ADDR, 8'h0F, 1'b1);
    check_regs("wrap_reg");
    check("scl_idle", SCL_O, 1);

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      case (kind)
        0: begin
          for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
          xfer_write(ADDR, 8'($urandom), 1'b1);
        end
        1: begin
          xfer_write(ADDR, 8'($urandom), 1'b0);
          xfer_read(ADDR, n);
        end
        2: xfer_read(ADDR, n);
        default: begin
          a = ADDR ^ (7'd1 << $urandom_range(0, 6));
          if ($urandom_range(0, 1) == 0) begin
            wdata_q.push_back(8'($urandom));
            xfer_write(a, 8'($urandom), 1'b1);
          end else begin
            xfer_read(a, 1);
          end
        end
      endcase
    end
    check_regs("rand_reg");

    // Reset in the middle of a data byte.
    bus_start();
    send_byte({ADDR, 1'b0}, ack);
    check("mid_addr_ack", ack, 0);
    send_byte(8'h07, ack);
    check("mid_ptr_ack", ack, 0);
    for (int i = 0; i < 4; i++) write_bit(1'(i));
    check("mid_busy", busy, 1);
    rst = 1'b0;
    tick(1);
    check("mid_rst_sda", SDA_O, 1);
    check("mid_rst_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mptr = 0;
    check_regs("mid_rst_reg");
    m_sda = 1'b1;
    tick(1);
    m_scl = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(4);
    wdata_q = '{8'($urandom), 8'($urandom)};
    xfer_write(ADDR, 8'h09, 1'b1);
    xfer_write(ADDR, 8'h09, 1'b0);
    xfer_read(ADDR, 2);
    check_regs("post_rst_reg");

    tick(10);
    check("wr_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
